grf_wb_arbiter: RTL

Write-port arbiter and scoreboard for the general register file. The pipeline write-back stage and a long-latency unit (multiply/divide, slow load) share the file's single write port. Long-latency results queue in a small FIFO, and the pipeline always wins the port except when starvation forces a one-cycle hold. A per-register pending scoreboard produces the read-after-write and write-after-write stall for the issue stage.

---
 rtl/grf_arb_pkg.sv | 17 +
 rtl/grf_arb_fifo.sv | 56 +++++
 rtl/grf_wb_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/grf_arb_pkg.sv
// Shared types for the general register file write-port arbiter.
package grf_arb_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    FORCE = 1'b1
  } arb_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } wr_req_t;

endpackage

// File: rtl/grf_arb_fifo.sv
// Small synchronous FIFO of register write requests for long-latency results.
// DEPTH must be a power of two so the pointers wrap naturally.
module grf_arb_fifo
  import grf_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_valid_i,
  output logic                     push_ready_o,
  input  wr_req_t                  push_data_i,
  input  logic                     pop_i,
  output wr_req_t                  head_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  wr_req_t         mem_q [DEPTH];
  logic [PW-1:0]   wrPtr_q;
  logic [PW-1:0]   rdPtr_q;
  logic [PW:0]     count_q;
  logic            pushFire;
  logic            popFire;

  assign full_o       = (count_q == (PW+1)'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign push_ready_o = !full_o;
  assign count_o      = count_q;
  assign head_o       = mem_q[rdPtr_q];
  assign pushFire     = push_valid_i && !full_o;
  assign popFire      = pop_i && !empty_o;

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves the count alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushFire) wrPtr_q <= wrPtr_q + PW'(1);
      if (popFire)  rdPtr_q <= rdPtr_q + PW'(1);
      if (pushFire && !popFire)      count_q <= count_q + (PW+1)'(1);
      else if (popFire && !pushFire) count_q <= count_q - (PW+1)'(1);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (pushFire) mem_q[wrPtr_q] <= push_data_i;
  end

endmodule

// File: rtl/grf_wb_arbiter.sv
// Write-port arbiter and pending scoreboard for the general register file.
// The pipeline write-back owns the port; queued long-latency results take idle
// cycles, and a one-cycle FORCE hold drains the FIFO when it has starved too long.
// Optional macro GRF_ARB_TRACE_EN prints every committed write.
module grf_wb_arbiter
  import grf_arb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic [31:0] wb_pc,
  output logic        wb_hold,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_addr,
  input  logic [31:0] lu_data,
  input  logic [31:0] lu_pc,
  input  logic        iss_valid,
  input  logic [4:0]  iss_addr,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  output logic        iss_stall,
  output logic        RegWrite,
  output logic [4:0]  Waddr,
  output logic [31:0] WData,
  output logic [31:0] PC
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 1);

  arb_state_e      state_q, state_d;
  logic [SW-1:0]   starveCnt_q, starveCnt_d;
  logic [31:0]     pending_q, pending_d;

  wr_req_t         luReq;
  wr_req_t         fifoHead;
  logic            fifoPushReady;
  logic            fifoEmpty;
  logic            fifoFull;
  logic [CW-1:0]   fifoCount;
  logic            pipeReq;
  logic            grantPipe;
  logic            grantFifo;
  logic            issSet;

  assign luReq.addr = lu_addr;
  assign luReq.data = lu_data;
  assign luReq.pc   = lu_pc;

  // Writes to $0 are acknowledged but never take a FIFO slot.
  grf_arb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_valid_i(lu_valid && (lu_addr != REG_ZERO)),
    .push_ready_o(fifoPushReady),
    .push_data_i (luReq),
    .pop_i       (grantFifo),
    .head_o      (fifoHead),
    .empty_o     (fifoEmpty),
    .full_o      (fifoFull),
    .count_o     (fifoCount)
  );

  assign lu_ready  = fifoPushReady;
  assign wb_hold   = (state_q == FORCE);
  assign pipeReq   = wb_we && (wb_addr != REG_ZERO);
  assign iss_stall = pending_q[A1] | pending_q[A2] | (iss_valid & pending_q[iss_addr]);
  assign issSet    = iss_valid && !iss_stall && (iss_addr != REG_ZERO);

  // Grant selection, starvation tracking, FSM next state and scoreboard update.
  always_comb begin
    grantPipe   = 1'b0;
    grantFifo   = 1'b0;
    state_d     = state_q;
    starveCnt_d = starveCnt_q;
    pending_d   = pending_q;
    case (state_q)
      ARB: begin
        if (pipeReq)         grantPipe = 1'b1;
        else if (!fifoEmpty) grantFifo = 1'b1;
        if (grantPipe && !fifoEmpty && (starveCnt_q == STARVE_LAST)) state_d = FORCE;
      end
      FORCE: begin
        grantFifo = !fifoEmpty;
        state_d   = ARB;
      end
    endcase
    if (grantFifo || fifoEmpty) starveCnt_d = '0;
    else if (grantPipe)         starveCnt_d = starveCnt_q + SW'(1);
    if (issSet)    pending_d[iss_addr]      = 1'b1;
    if (grantFifo) pending_d[fifoHead.addr] = 1'b0;
    pending_d[0] = 1'b0;
  end

  // State, starvation counter and scoreboard registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB;
      starveCnt_q <= '0;
      pending_q   <= '0;
    end else begin
      state_q     <= state_d;
      starveCnt_q <= starveCnt_d;
      pending_q   <= pending_d;
    end
  end

  // Register-file port mux driven by whichever source holds the grant.
  always_comb begin
    RegWrite = !reset && (grantPipe || grantFifo);
    Waddr    = wb_addr;
    WData    = wb_data;
    PC       = wb_pc;
    if (grantFifo) begin
      Waddr = fifoHead.addr;
      WData = fifoHead.data;
      PC    = fifoHead.pc;
    end
  end

  // The pipeline must not write while held; such a write would be dropped.
  assert property (@(posedge clk) disable iff (reset) (state_q == FORCE) |-> !wb_we);

  // FIFO status outputs must stay mutually consistent.
  assert property (@(posedge clk) disable iff (reset)
                   (fifoFull != fifoPushReady) && (fifoCount <= CW'(DEPTH)));

`ifdef GRF_ARB_TRACE_EN
  // Commit trace, plus a marker whenever a starvation drain begins.
  always @(posedge clk) begin
    if (RegWrite) $display("%d@%h: $%d <= %h", $time, PC, Waddr, WData);
    if (!reset && (state_q == ARB) && (state_d == FORCE))
      $display("%d: entering FORCE to drain $%d", $time, fifoHead.addr);
  end
`else
  // Trace disabled: no simulation output from this block.
`endif

endmodule
